// File: rtl/multiplier_4bits_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | multiplier_4bits_arbiter: round-robin sharing of one 4x4 multiplier     |
// | core among NUM_REQ requesters over valid/ready request/response ports.  |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module multiplier_4bits_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_a,
  input  logic [4*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [3:0]             mul_a,
  output logic [3:0]             mul_b,
  input  logic [7:0]             mul_product,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_product,
  output logic [2:0]             rsp_id,
  output logic [15:0]            done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  last_grant_q, last_grant_d;
  logic [3:0]  mul_a_q, mul_a_d;
  logic [3:0]  mul_b_q, mul_b_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_product_q, rsp_product_d;
  logic [2:0]  rsp_id_q, rsp_id_d;
  logic [15:0] done_count_q, done_count_d;

  logic [7:0]  valid_pad;
  logic [31:0] a_pad;
  logic [31:0] b_pad;
  logic [3:0]  scan_idx;
  logic [2:0]  grant_idx;
  logic        grant_found;

  assign valid_pad = 8'(req_valid);
  assign a_pad     = 32'(req_a);
  assign b_pad     = 32'(req_b);

  // Scan starts just past the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = {1'b0, last_grant_q} + 4'(k);
      if (scan_idx >= 4'(NUM_REQ)) begin
        scan_idx = scan_idx - 4'(NUM_REQ);
      end
      if (!grant_found && valid_pad[scan_idx[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[2:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && (state_q == IDLE) && grant_found && (grant_idx == 3'(i));
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_product_d = rsp_product_q;
    rsp_id_d      = rsp_id_q;
    done_count_d  = done_count_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          mul_a_d      = a_pad[{grant_idx, 2'b00} +: 4];
          mul_b_d      = b_pad[{grant_idx, 2'b00} +: 4];
          rsp_id_d     = grant_idx;
          last_grant_d = grant_idx;
          state_d      = CALC;
        end
      end
      CALC: begin
        rsp_product_d = mul_product;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          done_count_d = done_count_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 3'(NUM_REQ - 1);
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_product_q <= '0;
      rsp_id_q      <= '0;
      done_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_id_q      <= rsp_id_d;
      done_count_q  <= done_count_d;
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign rsp_id      = rsp_id_q;
  assign done_count  = done_count_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_4bits_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | tb_multiplier_4bits_arbiter: vector table plus scoreboard bench for     |
// | the shared-multiplier round-robin arbiter.                              |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_multiplier_4bits_arbiter;

  localparam int NUM_REQ = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3:0]           mul_a;
  logic [3:0]           mul_b;
  logic [7:0]           mul_product;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [7:0]           rsp_product;
  logic [2:0]           rsp_id;
  logic [15:0]          done_count;

  always #5 clk = ~clk;

  // Stand-in for the shared combinational multiplier core.
  assign mul_product = 8'(mul_a) * 8'(mul_b);

  multiplier_4bits_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_product(mul_product),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_product(rsp_product),
    .rsp_id     (rsp_id),
    .done_count (done_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard: expected {id, product} pushed at grant, popped at response handshake.
  logic [10:0] sb_q[$];
  logic [10:0] sb_exp;
  logic [15:0] exp_done;
  logic        preload;
  int          mon_g;
  logic [3:0]  mon_a;
  logic [3:0]  mon_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_done = 16'h0000;
    end else begin
      if (preload) exp_done = 16'hFFFF;
      if (req_ready != '0) begin
        check("grant_onehot", 32'($onehot(req_ready)), 32'd1);
        mon_g = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (req_ready[i]) mon_g = i;
        mon_a = req_a[4*mon_g +: 4];
        mon_b = req_b[4*mon_g +: 4];
        sb_q.push_back({3'(mon_g), 8'(mon_a) * 8'(mon_b)});
      end
      if (rsp_valid && rsp_ready) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          sb_exp = sb_q.pop_front();
          check("sb_rsp_id_product", 32'({rsp_id, rsp_product}), 32'(sb_exp));
        end
        check("sb_done_count", 32'(done_count), 32'(exp_done));
        exp_done = exp_done + 16'd1;
      end
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  hold;
    logic [2:0]  exp_g;
    logic [7:0]  exp_p;
  } vec_t;

  vec_t vecs[12];

  task automatic wait_grant(input logic [2:0] exp_g, input string name);
    int   waited;
    bit   seen;
    logic [3:0] exp_rr;
    waited = 0;
    seen   = 1'b0;
    exp_rr = 4'b0001 << exp_g;
    while (!seen && waited < 12) begin
      @(negedge clk);
      waited++;
      if (req_ready != '0) seen = 1'b1;
    end
    check({name, "_grant"}, 32'(req_ready), 32'(exp_rr));
    check({name, "_grant_latency"}, 32'(waited), 32'd1);
  endtask

  // Handshake edge, one CALC cycle, then response visible with rsp_ready as set.
  task automatic finish_op(input logic [3:0] hold, input logic [2:0] g, input logic [7:0] p,
                           input string name);
    @(posedge clk); #1;
    req_valid = hold;
    @(negedge clk);
    check({name, "_calc_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_calc_req_ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_rsp_product"}, 32'(rsp_product), 32'(p));
    check({name, "_rsp_id"}, 32'(rsp_id), 32'(g));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, 32'(req_ready), 32'd0);
    check({name, "_mul_ab"}, 32'({mul_a, mul_b}), 32'd0);
    check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_rsp_product"}, 32'(rsp_product), 32'd0);
    check({name, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({name, "_done_count"}, 32'(done_count), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    // a/b packed as {op3, op2, op1, op0}
    vecs[0]  = '{4'b0001, 16'h0002, 16'h0003, 4'b0000, 3'd0, 8'd6};
    vecs[1]  = '{4'b0010, 16'h00F0, 16'h00F0, 4'b0000, 3'd1, 8'd225};
    vecs[2]  = '{4'b1000, 16'h7000, 16'h9000, 4'b0000, 3'd3, 8'd63};
    vecs[3]  = '{4'b0100, 16'h0C00, 16'h0000, 4'b0000, 3'd2, 8'd0};
    vecs[4]  = '{4'b0101, 16'h0305, 16'h040B, 4'b0101, 3'd0, 8'd55};
    vecs[5]  = '{4'b0101, 16'h0305, 16'h040B, 4'b0000, 3'd2, 8'd12};
    vecs[6]  = '{4'b1000, 16'h0FDA, 16'h9FA3, 4'b0000, 3'd3, 8'd0};
    vecs[7]  = '{4'b1111, 16'h0FDA, 16'h9FA3, 4'b1111, 3'd0, 8'd30};
    vecs[8]  = '{4'b1111, 16'h0FDA, 16'h9FA3, 4'b1111, 3'd1, 8'd130};
    vecs[9]  = '{4'b1111, 16'h0FDA, 16'h9FA3, 4'b1111, 3'd2, 8'd225};
    vecs[10] = '{4'b1111, 16'h0FDA, 16'h9FA3, 4'b1111, 3'd3, 8'd0};
    vecs[11] = '{4'b1111, 16'h0FDA, 16'h9FA3, 4'b0000, 3'd0, 8'd30};

    preload   = 1'b0;
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      req_a     = vecs[i].a;
      req_b     = vecs[i].b;
      req_valid = vecs[i].valid;
      wait_grant(vecs[i].exp_g, $sformatf("vec%0d", i));
      finish_op(vecs[i].hold, vecs[i].exp_g, vecs[i].exp_p, $sformatf("vec%0d", i));
    end

    // Consumer back-pressure with all requests pending.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    wait_grant(3'd1, "bp");
    finish_op(4'b1111, 3'd1, 8'd130, "bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_rsp", c), 32'({rsp_valid, rsp_id, rsp_product}),
            32'({1'b1, 3'd1, 8'd130}));
      check($sformatf("bp_hold%0d_req_ready", c), 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_grant(3'd2, "bp_next");
    finish_op(4'b0000, 3'd2, 8'd225, "bp_next");

    // Reset while the FSM is in CALC.
    @(posedge clk); #1;
    req_valid = 4'b1111;
    wait_grant(3'd3, "rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_grant(3'd0, "post_rst");
    finish_op(4'b0000, 3'd0, 8'd30, "post_rst");

    // Counter wrap from a preloaded 0xFFFF.
    @(posedge clk); #1;
    force dut.done_count_q = 16'hFFFF;
    preload = 1'b1;
    #1;
    release dut.done_count_q;
    @(posedge clk); #1;
    preload   = 1'b0;
    req_valid = 4'b0001;
    wait_grant(3'd0, "wrap");
    finish_op(4'b0000, 3'd0, 8'd30, "wrap");
    @(negedge clk);
    check("wrap_done_count", 32'(done_count), 32'h0000);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiplier_4bits_arbiter.md
# multiplier_4bits_arbiter

Shares one combinational 4-bit × 4-bit multiplier core (`multiplier_4bits_version9`) among `NUM_REQ` requesters. Requests are granted round-robin over a valid/ready handshake. The grant's operands are registered onto the core inputs, and the 8-bit product is registered and returned with the requester ID over a valid/ready response channel. The block sits between the requesting units and the single multiplier instance, which it drives through its `mul_*` ports.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req_valid`  input  NUM_REQ  bit i: requester i has operands pending.
- `req_a`  input  4*NUM_REQ  operand A of requester i at bits [4i+3:4i]; unsigned.
- `req_b`  input  4*NUM_REQ  operand B of requester i at bits [4i+3:4i]; unsigned.
- `req_ready`  output  NUM_REQ  one-hot grant; bit i high means requester i's operands are taken at this edge.
- `mul_a`  output  4  registered operand A to the multiplier core.
- `mul_b`  output  4  registered operand B to the multiplier core.
- `mul_product`  input  8  combinational product returned by the multiplier core.
- `rsp_valid`  output  1  response valid.
- `rsp_ready`  input  1  consumer accepts the response.
- `rsp_product`  output  8  registered product, unsigned.
- `rsp_id`  output  3  index of the requester that owns `rsp_product`.
- `done_count`  output  16  count of completed responses; wraps.

## Operation
- The FSM has three states: IDLE, CALC and RESP.
- **IDLE:**
  - If any `req_valid` is high, select the grant g by scanning from `last_grant+1` upward with wrap-around; the first valid index wins.
  - `req_ready[g]` is asserted combinationally, and only for g.
  - At the clock edge: `mul_a`/`mul_b` take g's operands, `rsp_id` takes g, `last_grant` takes g, and the FSM moves to CALC.
  - If no request is valid, `req_ready` stays all-zero and the FSM stays in IDLE.
- **CALC:** `req_ready` is 0. At the edge, `rsp_product` takes `mul_product`, `rsp_valid` goes to 1, and the FSM moves to RESP.
- **RESP:**
  - `req_ready` is 0.
  - `rsp_valid`, `rsp_product` and `rsp_id` hold steady until `rsp_ready` is sampled high.
  - On that edge: `rsp_valid` goes to 0, `done_count` increments (0xFFFF wraps to 0x0000), and the FSM moves to IDLE.
- `req_valid` deasserting while the FSM is in CALC or RESP has no effect, because the operands are already captured.
- `req_valid` bits outside the range 0..NUM_REQ-1 do not exist. `rsp_id` upper bits are 0 when NUM_REQ ≤ 4.
- Arithmetic: the product is the unsigned 4×4→8 result. The maximum is 15×15 = 225, so there is no truncation.
- `mul_a` and `mul_b` keep their last values outside CALC, which avoids needless toggling of the core.

## Timing
- Reset values (asynchronous, while `rst_n` = 0):
  - FSM in IDLE; `last_grant` = NUM_REQ-1, so requester 0 has first priority.
  - `mul_a` = 0, `mul_b` = 0, `rsp_valid` = 0, `rsp_product` = 0, `rsp_id` = 0, `done_count` = 0.
  - `req_ready` is forced to all-zero.
- Latency:
  - The request handshake completes at edge E0.
  - `rsp_valid` is high after edge E0+1.
  - With `rsp_ready` tied high, the response is consumed at E0+2.
  - The next grant can occur at E0+3, giving a peak throughput of one operation per 3 cycles.
- Fairness: a continuously-valid requester is granted within NUM_REQ operations.
- If `rsp_ready` is already high when `rsp_valid` rises, the response completes on the first RESP edge.
- Reset mid-operation: an in-flight operation is discarded and no response is produced. After release, arbitration restarts from requester 0.
- No combinational path exists from `rsp_ready` to `req_ready`. `req_ready` depends only on state, `req_valid`, `last_grant` and `rst_n`.

## Test plan
- **Single request, immediate response:** reset, then `req_valid` = 0001, A0 = 2, B0 = 3, `rsp_ready` = 1.
  - `req_ready` = 0001 for one cycle.
  - 1 cycle later `rsp_valid` = 1 with `rsp_product` = 6 and `rsp_id` = 0.
  - `done_count` = 1.
- **Round-robin among all requesters:** all 4 valid, with A/B per requester = (10,3), (13,10), (15,15), (0,9), held valid.
  - Grants occur in order 0,1,2,3,0.
  - Products returned in order are 30, 130, 225, 0, 30, with IDs 0,1,2,3,0.
- **Consumer back-pressure:** `rsp_ready` = 0 for 5 cycles after `rsp_valid`.
  - `rsp_valid`, `rsp_product` and `rsp_id` stay stable.
  - `req_ready` stays 0 throughout, even with requests pending.
  - The next grant follows 1 cycle after `rsp_ready` is sampled high.
- **Pointer fairness after a skip:** grant requester 2, then assert `req_valid` = 0101.
  - The next grant goes to 0, because the scan runs 3→0 with wrap-around.
  - The grant after that goes to 2.
- **Reset mid-operation:** assert `rst_n` low while the FSM is in CALC.
  - All outputs take their reset values immediately.
  - No response is produced and `done_count` = 0.
  - After release, the first grant goes to requester 0.
- **Counter wrap:** preload by running 65536 operations, or force `done_count` to 0xFFFF.
  - The next completed response yields `done_count` = 0x0000.
